// File: rtl/if_handshake_responder_if.sv
// if_handshake_responder_if: four-phase req/ack bundle between initiator and responder
interface if_handshake_responder_if #(parameter int DW = 8);
   logic          req_in;
   logic [DW-1:0] data_in;
   logic          ack_out;
   modport master (output req_in, data_in, input ack_out);
   modport slave (input req_in, data_in, output ack_out);
endinterface

// File: rtl/if_handshake_responder.sv
// if_handshake_responder: four-phase responder buffering transfers into a FWFT FIFO; IF_RESP_REQ_SYNC_EN adds a 2-flop req synchronizer
module if_handshake_responder #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   if_handshake_responder_if.slave bus,
   output logic                    out_valid,
   output logic [DW-1:0]           out_data,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [15:0]             stall_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, ACK} state_t;
   state_t        state;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          req_seen, full, push, pop;
`ifdef IF_RESP_REQ_SYNC_EN
   logic [1:0]    req_sync;
   // two-flop synchronizer for the asynchronous request
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) req_sync <= '0;
      else req_sync <= {req_sync[0], bus.req_in};
   assign req_seen = req_sync[1];
`else
   assign req_seen = bus.req_in;
`endif
   assign full      = fifo_count == CW'(DEPTH);
   assign push      = state == IDLE && req_seen && !full;
   assign pop       = out_valid && out_ready;
   assign out_valid = fifo_count != '0;
   assign out_data  = mem[rd_ptr];
   // handshake FSM with registered acknowledge
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state       <= IDLE;
         bus.ack_out <= 1'b0;
      end else if (state == IDLE) begin
         if (push) begin
            state       <= ACK;
            bus.ack_out <= 1'b1;
         end
      end else if (!req_seen) begin
         state       <= IDLE;
         bus.ack_out <= 1'b0;
      end
   // saturating count of cycles a request waits on a full FIFO
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) stall_cnt <= '0;
      else if (state == IDLE && req_seen && full && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   // FIFO storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.data_in;
   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
endmodule

// File: tb/tb_if_handshake_responder.sv
// tb_if_handshake_responder: directed self-checking bench for if_handshake_responder
module tb_if_handshake_responder;
`ifdef IF_RESP_REQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   logic       clk = 1'b0;
   logic       reset_n;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] fifo_count;
   logic [15:0] stall_cnt;
   int         total = 0;
   int         bad = 0;
   logic       mon_en = 1'b0;
   logic [2:0] max_cnt;
   logic [7:0] popped [$];
   if_handshake_responder_if #(.DW(8)) bus ();
   if_handshake_responder #(.DEPTH(4), .DW(8)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .fifo_count(fifo_count), .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (mon_en) begin
         if (out_valid && out_ready) popped.push_back(out_data);
         if (fifo_count > max_cnt) max_cnt = fifo_count;
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic xfer(input logic [7:0] d);
      int n;
      bus.req_in = 1'b1;
      bus.data_in = d;
      n = 0;
      while (bus.ack_out !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL xfer_ack_rise data=%h: ack=%b want 1", d, bus.ack_out); end
      bus.req_in = 1'b0;
      n = 0;
      while (bus.ack_out !== 1'b0 && n < 20) begin tick(); n++; end
      total++;
      if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL xfer_ack_fall data=%h: ack=%b want 0", d, bus.ack_out); end
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      bus.req_in = 1'b0;
      bus.data_in = '0;
      out_ready = 1'b0;
      tick();
      tick();
      total++;
      if (bus.ack_out !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0 || stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset: ack=%b valid=%b count=%0d stall=%0d want 0 0 0 0", bus.ack_out, out_valid, fifo_count, stall_cnt);
      end
      reset_n = 1'b1;
      tick();
   endtask
   task automatic test_single();
      bus.req_in = 1'b1;
      bus.data_in = 8'hA5;
      repeat (LAT - 1) begin
         tick();
         total++;
         if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL single_early_ack: ack=%b want 0", bus.ack_out); end
      end
      tick();
      total++;
      if (bus.ack_out !== 1'b1 || fifo_count !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
         bad++;
         $display("FAIL single_push: ack=%b count=%0d valid=%b data=%h want 1 1 1 a5", bus.ack_out, fifo_count, out_valid, out_data);
      end
      bus.req_in = 1'b0;
      repeat (LAT) tick();
      total++;
      if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL single_ack_drop: ack=%b want 0", bus.ack_out); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_pop: count=%0d valid=%b want 0 0", fifo_count, out_valid); end
   endtask
   task automatic test_fill_stall();
      for (int i = 1; i <= 4; i++) xfer(8'(i));
      total++;
      if (fifo_count !== 3'd4) begin bad++; $display("FAIL fill_count: count=%0d want 4", fifo_count); end
      bus.req_in = 1'b1;
      bus.data_in = 8'h05;
      repeat (10) tick();
      total++;
      if (bus.ack_out !== 1'b0 || fifo_count !== 3'd4 || stall_cnt !== 16'(10 - (LAT - 1))) begin
         bad++;
         $display("FAIL stall: ack=%b count=%0d stall=%0d want 0 4 %0d", bus.ack_out, fifo_count, stall_cnt, 10 - (LAT - 1));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (bus.ack_out !== 1'b0 || fifo_count !== 3'd3 || out_data !== 8'h02) begin
         bad++;
         $display("FAIL stall_pop: ack=%b count=%0d data=%h want 0 3 02", bus.ack_out, fifo_count, out_data);
      end
      tick();
      total++;
      if (bus.ack_out !== 1'b1 || fifo_count !== 3'd4) begin bad++; $display("FAIL stall_release: ack=%b count=%0d want 1 4", bus.ack_out, fifo_count); end
      bus.req_in = 1'b0;
      repeat (LAT) tick();
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 8'(i)) begin bad++; $display("FAIL drain_order: valid=%b data=%h want 1 %h", out_valid, out_data, 8'(i)); end
         tick();
      end
      out_ready = 1'b0;
      total++;
      if (fifo_count !== 3'd0) begin bad++; $display("FAIL drain_empty: count=%0d want 0", fifo_count); end
   endtask
   task automatic test_wrap();
      popped.delete();
      max_cnt = '0;
      mon_en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) xfer(8'h10 + 8'(i));
      tick();
      tick();
      mon_en = 1'b0;
      out_ready = 1'b0;
      total++;
      if (popped.size() != 9) begin bad++; $display("FAIL wrap_count: popped=%0d want 9", popped.size()); end
      for (int i = 0; i < 9 && i < popped.size(); i++) begin
         total++;
         if (popped[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, popped[i], 8'h10 + 8'(i)); end
      end
      total++;
      if (max_cnt > 3'd1) begin bad++; $display("FAIL wrap_max_count: max=%0d want <=1", max_cnt); end
   endtask
   task automatic test_back_to_back();
      xfer(8'h20);
      xfer(8'h21);
      total++;
      if (fifo_count !== 3'd2 || out_data !== 8'h20) begin bad++; $display("FAIL simul_pre: count=%0d data=%h want 2 20", fifo_count, out_data); end
      bus.req_in = 1'b1;
      bus.data_in = 8'h22;
      repeat (LAT - 1) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (bus.ack_out !== 1'b1 || fifo_count !== 3'd2 || out_data !== 8'h21) begin
         bad++;
         $display("FAIL simul_push_pop: ack=%b count=%0d data=%h want 1 2 21", bus.ack_out, fifo_count, out_data);
      end
      bus.req_in = 1'b0;
      repeat (LAT) tick();
      out_ready = 1'b1;
      tick();
      total++;
      if (out_data !== 8'h22 || fifo_count !== 3'd1) begin bad++; $display("FAIL simul_tail: data=%h count=%0d want 22 1", out_data, fifo_count); end
      tick();
      out_ready = 1'b0;
   endtask
   task automatic test_reset_mid();
      xfer(8'h30);
      xfer(8'h31);
      bus.req_in = 1'b1;
      bus.data_in = 8'h32;
      repeat (LAT) tick();
      total++;
      if (bus.ack_out !== 1'b1 || fifo_count !== 3'd3) begin bad++; $display("FAIL mid_pre: ack=%b count=%0d want 1 3", bus.ack_out, fifo_count); end
      reset_n = 1'b0;
      bus.data_in = 8'h33;
      #1;
      total++;
      if (bus.ack_out !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_async_reset: ack=%b count=%0d valid=%b want 0 0 0", bus.ack_out, fifo_count, out_valid);
      end
      tick();
      reset_n = 1'b1;
      repeat (LAT - 1) tick();
      tick();
      total++;
      if (bus.ack_out !== 1'b1 || fifo_count !== 3'd1 || out_data !== 8'h33) begin
         bad++;
         $display("FAIL mid_reaccept: ack=%b count=%0d data=%h want 1 1 33", bus.ack_out, fifo_count, out_data);
      end
      bus.req_in = 1'b0;
      repeat (LAT) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
`ifdef IF_RESP_REQ_SYNC_EN
   task automatic test_sync_latency();
      logic exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.req_in = 1'b1;
      bus.data_in = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) bus.req_in = 1'b0;
         tick();
         total++;
         if (bus.ack_out !== exp[i]) begin bad++; $display("FAIL sync_latency[%0d]: ack=%b want %b", i, bus.ack_out, exp[i]); end
      end
      total++;
      if (out_data !== 8'h3C) begin bad++; $display("FAIL sync_data: data=%h want 3c", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
`endif
   initial begin
      test_reset();
      test_single();
      test_fill_stall();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef IF_RESP_REQ_SYNC_EN
      test_sync_latency();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/if_handshake_responder.md
Name: if_handshake_responder

Overview:
- Responder end of the team's four-phase request/acknowledge interface. The initiator drives req_in (signal_a role) and an 8-bit data_in (data role). This block drives ack_out (signal_b role).
- Each accepted transfer is buffered in a small FIFO and presented to a local consumer on a valid/ready port.
- Sits between an interface-bundle port and downstream logic in the same hierarchy as the interface-based child modules.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- DW, 8, data width of data_in and out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_in  input  1  request from initiator (four-phase: raise, wait ack, drop, wait ack drop).
- data_in  input  DW  payload; must be stable while req_in=1.
- ack_out  input/output: output  1  acknowledge to initiator; registered.
- out_valid  output  1  FIFO holds at least one entry.
- out_data  output  DW  head-of-FIFO data (first-word-fall-through).
- out_ready  input  1  consumer accepts head when out_valid=1.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- stall_cnt  output  16  cycles spent with req pending but FIFO full; saturating.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values while reset_n=0:
  - ack_out=0, out_valid=0, fifo_count=0, stall_cnt=0.
  - Read and write pointers = 0, FSM = IDLE.
  - out_data is undefined but must not be X-propagating into valid; the bench checks it only when out_valid=1.
- FSM states: IDLE and ACK.
- IDLE, push:
  - Condition: req_seen=1 and fifo_count<DEPTH.
  - At that edge: write data_in to mem[wr_ptr], wr_ptr+1 (wraps at DEPTH), go to ACK.
  - ack_out=1 registered at the same edge. Latency from req sampled to ack visible is 1 cycle.
- IDLE, stall:
  - Condition: req_seen=1 and fifo_count==DEPTH.
  - No write, ack_out stays 0, stay in IDLE.
  - stall_cnt increments, saturating at 16'hFFFF.
- ACK:
  - ack_out held at 1.
  - On req_seen=0: ack_out=0 at that edge, go to IDLE.
  - data_in is ignored in ACK.
- Full check uses the current fifo_count. A pop in the same cycle does not free space for a push in that cycle.
- FIFO pop: when out_valid&&out_ready, rd_ptr+1 (wraps). out_ready while out_valid=0 is ignored.
- Simultaneous push and pop: fifo_count unchanged, both pointers advance.
- fifo_count: +1 on push only, -1 on pop only.
- out_valid = (fifo_count!=0), combinational from registered count.
- out_data = mem[rd_ptr].
- Pointer width: $clog2(DEPTH). Occupancy is tracked by fifo_count, not by pointer compare.
- Reset mid-handshake:
  - All state is cleared and FIFO contents are discarded.
  - If req_in is still 1 after reset release, it is treated as a new request and accepted normally.
- Maximum throughput: one transfer per 2 cycles plus initiator turnaround.

Optional Feature:
- Macro: IF_RESP_REQ_SYNC_EN.
- Defined:
  - req_in passes through a 2-flop synchronizer (both flops reset to 0) before the FSM; req_seen is the second flop.
  - ack latency becomes 3 cycles from req_in rise.
  - data_in is still sampled directly at the push edge, so the initiator must hold data stable throughout req_in=1.
- Undefined: req_seen=req_in, 1-cycle latency as above.

Test Plan:
- Single transfer, feature off:
  - Stimulus: req_in=1 with data_in=8'hA5, out_ready=0.
  - Required: ack_out=1 one cycle later; fifo_count=1; out_valid=1, out_data=8'hA5.
  - Then drop req_in: ack_out=0 one cycle later.
- Fill and stall, DEPTH=4:
  - Stimulus: push 8'h01..8'h04 with out_ready=0, then a 5th request 8'h05 held 10 cycles.
  - Required: ack_out stays 0, fifo_count=4, stall_cnt=10.
  - Then pulse out_ready one cycle: pops 8'h01, 5th push is acknowledged, and the drain order is 02,03,04,05.
- Wrap-around:
  - Stimulus: 9 transfers 8'h10..8'h18 with out_ready=1 throughout.
  - Required: outputs appear in order with no loss; fifo_count never exceeds 1.
- Simultaneous push/pop:
  - Stimulus: fifo_count=2, push edge coincides with a pop.
  - Required: fifo_count stays 2, head advances to the 2nd entry.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 while in ACK with fifo_count=3, req_in held 1.
  - Required: immediately ack_out=0, fifo_count=0, out_valid=0.
  - After release: ack_out=1 one cycle later, fifo_count=1.
- IF_RESP_REQ_SYNC_EN defined:
  - Stimulus: req_in rise with 8'h3C.
  - Required: ack_out=1 exactly 3 cycles later, out_data=8'h3C.
  - Then req_in fall: ack_out=0 3 cycles later.
